// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_buffer
// Purpose  : Collects byte writes into masked 16-bit word writes, queues the
//            words in a circular FIFO and drains them to the SDRAM controller
//            through a show-ahead output register with a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_write_buffer #(
    parameter int ADDRESS_WIDTH = 25,
    parameter int DEPTH_LOG2    = 4,
    parameter int FLUSH_CYCLES  = 64
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr_in,
    input  logic [7:0]               wr_data_in,
    input  logic                     wr_valid_in,
    output logic                     fifo_full,
    output logic [ADDRESS_WIDTH-2:0] sdram_addr,
    output logic [15:0]              sdram_data,
    output logic [1:0]               sdram_be,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    output logic [DEPTH_LOG2:0]      fifo_level,
    output logic                     overflow
);

    localparam int c_DEPTH   = 1 << DEPTH_LOG2;
    localparam int c_IDLE_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int c_WORD_W  = (ADDRESS_WIDTH - 1) + 16 + 2;
    localparam int c_LVL_W   = DEPTH_LOG2 + 1;

    localparam logic [c_IDLE_W-1:0]   c_IDLE_LAST = c_IDLE_W'(FLUSH_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_ONE  = c_IDLE_W'(1);
    localparam logic [c_LVL_W-1:0]    c_LVL_CAP   = c_LVL_W'(c_DEPTH);
    localparam logic [c_LVL_W-1:0]    c_LVL_HIGH  = c_LVL_W'(c_DEPTH - 1);
    localparam logic [c_LVL_W-1:0]    c_LVL_ONE   = c_LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [0:0] {
        S_EMPTY   = 1'b0,
        S_PARTIAL = 1'b1
    } pend_state_t;

    // Pending word register
    pend_state_t              state_q,     state_d;
    logic [ADDRESS_WIDTH-2:0] pend_addr_q, pend_addr_d;
    logic [15:0]              pend_data_q, pend_data_d;
    logic [1:0]               pend_be_q,   pend_be_d;
    logic [c_IDLE_W-1:0]      idle_q,      idle_d;

    // FIFO
    logic [c_WORD_W-1:0]      mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr_q;
    logic [DEPTH_LOG2-1:0]    rd_ptr_q;
    logic [c_LVL_W-1:0]       level_q, level_d;
    logic                     full_q;
    logic                     ovf_q;

    // Output register
    logic [ADDRESS_WIDTH-2:0] out_addr_q;
    logic [15:0]              out_data_q;
    logic [1:0]               out_be_q;
    logic                     out_req_q;

    // Combinational decode of the incoming byte
    logic [ADDRESS_WIDTH-2:0] w_new_addr;
    logic [15:0]              w_new_data;
    logic [1:0]               w_new_be;
    logic                     w_mergeable;
    logic                     w_fifo_at_cap;
    logic                     w_push_req;
    logic                     w_push_ok;
    logic                     w_drop;
    logic                     w_pop;
    logic [c_WORD_W-1:0]      w_push_word;

    assign w_new_addr    = wr_addr_in[ADDRESS_WIDTH-1:1];
    assign w_new_data    = wr_addr_in[0] ? {wr_data_in, 8'h00} : {8'h00, wr_data_in};
    assign w_new_be      = wr_addr_in[0] ? 2'b10 : 2'b01;
    assign w_mergeable   = (pend_addr_q == w_new_addr) && ((pend_be_q & w_new_be) == 2'b00);
    assign w_fifo_at_cap = (level_q == c_LVL_CAP);
    assign w_push_ok     = w_push_req && !w_fifo_at_cap;
    // Only a byte can be lost; a blocked idle flush simply retries next cycle.
    assign w_drop        = w_push_req && w_fifo_at_cap && wr_valid_in;
    assign w_pop         = (level_q != '0) && (!out_req_q || sdram_ack);

    // Pending-word next state: decides what gets pushed and what stays pending
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        idle_d      = idle_q;
        w_push_req  = 1'b0;
        w_push_word = {pend_addr_q, pend_data_q, pend_be_q};
        case (state_q)
            S_EMPTY: begin
                idle_d = '0;
                if (wr_valid_in) begin
                    pend_addr_d = w_new_addr;
                    pend_data_d = w_new_data;
                    pend_be_d   = w_new_be;
                    state_d     = S_PARTIAL;
                end
            end
            default: begin
                if (wr_valid_in) begin
                    idle_d     = '0;
                    w_push_req = 1'b1;
                    if (w_mergeable) begin
                        // Second half of the word: push the completed word now
                        w_push_word = {pend_addr_q, pend_data_q | w_new_data,
                                       pend_be_q | w_new_be};
                        if (!w_fifo_at_cap) begin
                            state_d = S_EMPTY;
                        end
                    end else if (!w_fifo_at_cap) begin
                        // Push the old word as-is, the new byte starts a new one
                        pend_addr_d = w_new_addr;
                        pend_data_d = w_new_data;
                        pend_be_d   = w_new_be;
                    end
                end else if (idle_q == c_IDLE_LAST) begin
                    w_push_req = 1'b1;
                    if (!w_fifo_at_cap) begin
                        state_d = S_EMPTY;
                        idle_d  = '0;
                    end
                end else begin
                    idle_d = idle_q + c_IDLE_ONE;
                end
            end
        endcase
    end

    // Pending-word FSM state and register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_EMPTY;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_be_q   <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
            idle_q      <= idle_d;
        end
    end

    // FIFO storage written at the tail on every accepted push
    always_ff @(posedge clk_sys) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= w_push_word;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the level unchanged
    always_comb begin
        level_d = level_q;
        if (w_push_ok && !w_pop) begin
            level_d = level_q + c_LVL_ONE;
        end else if (!w_push_ok && w_pop) begin
            level_d = level_q - c_LVL_ONE;
        end
    end

    // FIFO pointers, level, registered full flag and sticky overflow
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            level_q <= level_d;
            // Lags the level by one cycle; the spare entry covers the byte in flight
            full_q  <= (level_q >= c_LVL_HIGH);
            ovf_q   <= ovf_q | w_drop;
        end
    end

    // Show-ahead output register: refill when empty or when being consumed
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            out_addr_q <= '0;
            out_data_q <= '0;
            out_be_q   <= '0;
            out_req_q  <= 1'b0;
        end else if (w_pop) begin
            {out_addr_q, out_data_q, out_be_q} <= mem_q[rd_ptr_q];
            out_req_q <= 1'b1;
        end else if (sdram_ack) begin
            out_req_q <= 1'b0;
        end
    end

    assign fifo_full  = full_q;
    assign sdram_addr = out_addr_q;
    assign sdram_data = out_data_q;
    assign sdram_be   = out_be_q;
    assign sdram_req  = out_req_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_buffer
// Purpose  : Directed and randomized checks of mem_write_buffer against a
//            byte-stream reference model (word merging, flush, overflow,
//            back-pressure, output hold under stall, asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write_buffer;

    localparam int AW    = 25;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int FLUSH = 64;

    typedef struct packed {
        logic [AW-2:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } word_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] wr_addr_in;
    logic [7:0]    wr_data_in;
    logic          wr_valid_in;
    logic          fifo_full;
    logic [AW-2:0] sdram_addr;
    logic [15:0]   sdram_data;
    logic [1:0]    sdram_be;
    logic          sdram_req;
    logic          sdram_ack;
    logic [DL2:0]  fifo_level;
    logic          overflow;

    always #5 clk_sys = ~clk_sys;

    mem_write_buffer #(
        .ADDRESS_WIDTH (AW),
        .DEPTH_LOG2    (DL2),
        .FLUSH_CYCLES  (FLUSH)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .wr_valid_in (wr_valid_in),
        .fifo_full   (fifo_full),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_be    (sdram_be),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    word_t exp_q[$];
    word_t got_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    ack_mode = 0;      // 0: ack low, 1: ack high, 2: random
    bit    m_valid  = 1'b0;   // model: a partial word is pending
    word_t m_pend;
    int    m_idle   = 0;
    bit    m_cap    = 1'b0;   // model: apply the 16+1 word capacity limit
    bit    prev_stall = 1'b0;
    word_t prev_word;
    bit    chk_full_next;
    bit    done15;
    bit    stuck;
    int    guard;
    logic [AW-1:0] base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic word_t cur_word();
        return {sdram_addr, sdram_data, sdram_be};
    endfunction

    function automatic word_t masked(input word_t w);
        word_t r = w;
        r.data = w.data & {{8{w.be[1]}}, {8{w.be[0]}}};
        return r;
    endfunction

    function automatic word_t got_at(input int k);
        if (k < got_q.size()) return masked(got_q[k]);
        return '1;
    endfunction

    function automatic word_t mk(input logic [AW-1:0] a, input logic [7:0] d);
        word_t w;
        w.addr = a[AW-1:1];
        w.data = a[0] ? {d, 8'h00} : {8'h00, d};
        w.be   = a[0] ? 2'b10 : 2'b01;
        return w;
    endfunction

    // Reference model: one incoming byte
    task automatic m_byte(input logic [AW-1:0] a, input logic [7:0] d);
        word_t n;
        n      = mk(a, d);
        m_idle = 0;
        if (!m_valid) begin
            m_pend  = n;
            m_valid = 1'b1;
        end else if (m_cap && exp_q.size() >= DEPTH + 1) begin
            // no room anywhere: byte lost, pending word untouched
        end else if (m_pend.addr == n.addr && (m_pend.be & n.be) == 2'b00) begin
            exp_q.push_back({m_pend.addr, m_pend.data | n.data, m_pend.be | n.be});
            m_valid = 1'b0;
        end else begin
            exp_q.push_back(m_pend);
            m_pend = n;
        end
    endtask

    // Reference model: one cycle without a byte
    task automatic m_idle_cycle();
        if (m_valid) begin
            m_idle++;
            if (m_idle == FLUSH) begin
                exp_q.push_back(m_pend);
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: check held outputs, drive inputs, record an accepted word
    task automatic step(input bit v, input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        if (prev_stall) begin
            check("hold_req", 64'(sdram_req), 64'd1);
            check("hold_word", 64'(cur_word()), 64'(prev_word));
        end
        wr_valid_in = v;
        wr_addr_in  = a;
        wr_data_in  = d;
        if (v) m_byte(a, d);
        else   m_idle_cycle();
        case (ack_mode)
            0:       sdram_ack = 1'b0;
            1:       sdram_ack = 1'b1;
            default: sdram_ack = 1'($urandom_range(0, 1));
        endcase
        if (sdram_req && sdram_ack) got_q.push_back(cur_word());
        prev_stall = sdram_req && !sdram_ack;
        prev_word  = cur_word();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, '0, '0);
            if (!m_valid && got_q.size() == exp_q.size() && !sdram_req && fifo_level == 0) break;
        end
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_word"}, 64'(masked(got_q[i])), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_model();
        m_valid    = 1'b0;
        m_idle     = 0;
        prev_stall = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        wr_valid_in = 1'b0;
        sdram_ack   = 1'b0;
        clear_model();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   64'(sdram_req),  64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_full"},  64'(fifo_full),  64'd0);
        check({tag, "_ovf"},   64'(overflow),   64'd0);
        check({tag, "_word"},  64'(cur_word()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_valid_in = 1'b0;
        wr_addr_in  = '0;
        wr_data_in  = '0;
        sdram_ack   = 1'b0;
        reset_n     = 1'b0;
        repeat (2) @(negedge clk_sys);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Two bytes of one word on consecutive cycles -> one merged transfer
        ack_mode = 1;
        step(1'b1, 25'h10, 8'hAA);
        step(1'b1, 25'h11, 8'h55);
        step(1'b0, '0, '0);
        check("t1_level_push", 64'(fifo_level), 64'd1);
        check("t1_req_latency", 64'(sdram_req), 64'd0);
        step(1'b0, '0, '0);
        check("t1_req_rise", 64'(sdram_req), 64'd1);
        check("t1_level_pop", 64'(fifo_level), 64'd0);
        drain(100);
        check("t1_word", 64'(got_at(0)), 64'({24'h000008, 16'h55AA, 2'b11}));
        check("t1_level_end", 64'(fifo_level), 64'd0);
        compare_streams("t1");

        // Lone byte flushed after the idle period
        do_reset();
        ack_mode = 1;
        step(1'b1, 25'h21, 8'h3C);
        repeat (FLUSH) step(1'b0, '0, '0);
        check("t2_no_early_push", 64'(fifo_level), 64'd0);
        step(1'b0, '0, '0);
        check("t2_push_edge", 64'(fifo_level), 64'd1);
        check("t2_req_low", 64'(sdram_req), 64'd0);
        step(1'b0, '0, '0);
        check("t2_req_high", 64'(sdram_req), 64'd1);
        drain(100);
        check("t2_word", 64'(got_at(0)), 64'({24'h000010, 16'h3C00, 2'b10}));
        compare_streams("t2");

        // Different words are never merged and keep their order
        do_reset();
        ack_mode = 1;
        step(1'b1, 25'h00, 8'h11);
        step(1'b1, 25'h02, 8'h22);
        step(1'b1, 25'h00, 8'h33);
        drain(200);
        check("t3_w0", 64'(got_at(0)), 64'({24'h000000, 16'h0011, 2'b01}));
        check("t3_w1", 64'(got_at(1)), 64'({24'h000001, 16'h0022, 2'b01}));
        check("t3_w2", 64'(got_at(2)), 64'({24'h000000, 16'h0033, 2'b01}));
        compare_streams("t3");

        // No acks, 32 words written: fill, full flag, drops, sticky overflow
        do_reset();
        ack_mode      = 0;
        m_cap         = 1'b1;
        chk_full_next = 1'b0;
        done15        = 1'b0;
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 2; b++) begin
                step(1'b1, 25'h100 + 25'(2 * w + b), 8'($urandom));
                if (chk_full_next) begin
                    check("t4_full_rise", 64'(fifo_full), 64'd1);
                    chk_full_next = 1'b0;
                    done15        = 1'b1;
                end else if (fifo_level == 15 && !done15) begin
                    chk_full_next = 1'b1;
                end
                if (fifo_level == 13) check("t4_full_low", 64'(fifo_full), 64'd0);
            end
        end
        repeat (2) step(1'b0, '0, '0);
        check("t4_level_cap", 64'(fifo_level), 64'd16);
        check("t4_full", 64'(fifo_full), 64'd1);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_req", 64'(sdram_req), 64'd1);
        repeat (FLUSH + 6) step(1'b0, '0, '0);
        check("t4_level_hold", 64'(fifo_level), 64'd16);
        ack_mode = 1;
        drain(300);
        step(1'b0, '0, '0);
        check("t4_level_empty", 64'(fifo_level), 64'd0);
        check("t4_full_clear", 64'(fifo_full), 64'd0);
        check("t4_overflow_sticky", 64'(overflow), 64'd1);
        compare_streams("t4");
        m_cap = 1'b0;

        // Asynchronous reset with a request outstanding and 5 words queued
        do_reset();
        check("t6_ovf_cleared", 64'(overflow), 64'd0);
        ack_mode = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 25'h200 + 25'(i), 8'($urandom));
        repeat (2) step(1'b0, '0, '0);
        check("t6_level5", 64'(fifo_level), 64'd5);
        check("t6_req_before", 64'(sdram_req), 64'd1);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        wr_valid_in = 1'b0;
        clear_model();
        repeat (2) @(negedge clk_sys);
        reset_n  = 1'b1;
        ack_mode = 1;
        step(1'b1, 25'h40, 8'h12);
        step(1'b1, 25'h41, 8'h34);
        drain(100);
        check("t6_after", 64'(got_at(0)), 64'({24'h000020, 16'h3412, 2'b11}));
        compare_streams("t6");

        // Random stalls on a 200-byte sequential stream, honouring back-pressure
        do_reset();
        ack_mode = 2;
        stuck    = 1'b0;
        base     = 25'($urandom);
        for (int i = 0; i < 200; i++) begin
            guard = 0;
            while (fifo_full && guard < 1000) begin
                step(1'b0, '0, '0);
                guard++;
            end
            if (guard >= 1000) stuck = 1'b1;
            step(1'b1, base + 25'(i), 8'($urandom));
        end
        drain(3000);
        check("t5_no_stuck", 64'(stuck), 64'd0);
        check("t5_no_overflow", 64'(overflow), 64'd0);
        compare_streams("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
